// File: rtl/sub_serial.sv
// ---------------------------------------------------------------------------
// sub_serial -- slice-serial subtractor, Y = A - B - IB
//
// Processes SLICE bits per clock, LSB slice first. The borrow ripples between
// slices through a register, so a LEN-bit subtract takes N = LEN/SLICE cycles
// of RUN. Operands are captured on the input handshake. The result is held
// until the consumer takes it.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active high
//   a_i          minuend       (sampled on in_valid_i & in_ready_o)
//   b_i          subtrahend    (sampled on in_valid_i & in_ready_o)
//   ib_i         borrow-in     (sampled on in_valid_i & in_ready_o)
//   in_valid_i   operands present
//   in_ready_o   block idle and able to accept operands
//   y_o          difference, meaningful only while out_valid_o = 1
//   ob_o         borrow-out, 1 iff unsigned A < B + IB
//   ovf_o        signed two's-complement overflow of A - B - IB
//   out_valid_o  result present
//   out_ready_i  consumer takes result
//
// LEN must be an integer multiple of SLICE. SLICE = LEN (one RUN cycle) is
// legal.
// ---------------------------------------------------------------------------
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | waiting for operands, in_ready_o = 1
// S_RUN  | one slice per edge, counter selects the slice
// S_DONE | result valid, held until out_ready_i
// ---------------------------------------------------------------------------
module sub_serial #(
    parameter int LEN   = 16,
    parameter int SLICE = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [LEN-1:0] a_i,
    input  logic [LEN-1:0] b_i,
    input  logic           ib_i,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    output logic [LEN-1:0] y_o,
    output logic           ob_o,
    output logic           ovf_o,
    output logic           out_valid_o,
    input  logic           out_ready_i
);

    localparam int N  = LEN / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           borrow_q, borrow_d;
    logic [LEN-1:0] a_q, a_d;
    logic [LEN-1:0] b_q, b_d;
    logic [LEN-1:0] y_q, y_d;
    logic           ob_q, ob_d;
    logic           ovf_q, ovf_d;
    logic           out_valid_q, out_valid_d;

    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE:0]   diff;
    logic             last_slice;

    // Current slice of each operand; the extra MSB of diff is the borrow out
    // of this slice.
    assign a_sl       = a_q[cnt_q*SLICE +: SLICE];
    assign b_sl       = b_q[cnt_q*SLICE +: SLICE];
    assign diff       = {1'b0, a_sl} - {1'b0, b_sl} - {{SLICE{1'b0}}, borrow_q};
    assign last_slice = (cnt_q == CW'(N - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        borrow_d    = borrow_q;
        a_d         = a_q;
        b_d         = b_q;
        y_d         = y_q;
        ob_d        = ob_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    a_d      = a_i;
                    b_d      = b_i;
                    borrow_d = ib_i;
                    cnt_d    = '0;
                    y_d      = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                y_d[cnt_q*SLICE +: SLICE] = diff[SLICE-1:0];
                borrow_d = diff[SLICE];
                cnt_d    = cnt_q + CW'(1);
                if (last_slice) begin
                    ob_d = diff[SLICE];
                    // diff[SLICE-1] is the freshly computed result MSB; y_q does
                    // not hold it yet.
                    ovf_d       = (a_q[LEN-1] != b_q[LEN-1]) &&
                                  (diff[SLICE-1] != a_q[LEN-1]);
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            borrow_q    <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            y_q         <= '0;
            ob_q        <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            borrow_q    <= borrow_d;
            a_q         <= a_d;
            b_q         <= b_d;
            y_q         <= y_d;
            ob_q        <= ob_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign y_o         = y_q;
    assign ob_o        = ob_q;
    assign ovf_o       = ovf_q;
    assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_sub_serial.sv
// ---------------------------------------------------------------------------
// tb_sub_serial -- directed bench for sub_serial.
// Three instances (SLICE = 1, 4, 16) share the operand inputs. The directed
// steps exercise the SLICE = 4 instance. The sweep at the end checks all
// three against a reference difference.
// ---------------------------------------------------------------------------
module tb_sub_serial;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a   = '0;
    logic [15:0] b   = '0;
    logic        ib  = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready  [3];
    logic [15:0] y         [3];
    logic        ob        [3];
    logic        ovf       [3];
    logic        out_valid [3];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sub_serial #(.LEN(16), .SLICE(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .a_i(a), .b_i(b), .ib_i(ib),
        .in_valid_i(in_valid), .in_ready_o(in_ready[0]), .y_o(y[0]),
        .ob_o(ob[0]), .ovf_o(ovf[0]), .out_valid_o(out_valid[0]),
        .out_ready_i(out_ready)
    );
    sub_serial #(.LEN(16), .SLICE(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .a_i(a), .b_i(b), .ib_i(ib),
        .in_valid_i(in_valid), .in_ready_o(in_ready[1]), .y_o(y[1]),
        .ob_o(ob[1]), .ovf_o(ovf[1]), .out_valid_o(out_valid[1]),
        .out_ready_i(out_ready)
    );
    sub_serial #(.LEN(16), .SLICE(16)) dut16 (
        .clk_i(clk), .rst_i(rst), .a_i(a), .b_i(b), .ib_i(ib),
        .in_valid_i(in_valid), .in_ready_o(in_ready[2]), .y_o(y[2]),
        .ob_o(ob[2]), .ovf_o(ovf[2]), .out_valid_o(out_valid[2]),
        .out_ready_i(out_ready)
    );

    function automatic int nslices(input int i);
        return 16 >> (2 * i);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int i);
        for (int k = 0; k < 60 && in_ready[i] !== 1'b1; k++) step();
        chk("in_ready_wait", 32'(in_ready[i]), 1);
    endtask

    // One operation on the SLICE=4 instance with consumer always ready.
    task automatic do_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic ibv, input logic [15:0] ey, input logic eob,
                         input logic eovf);
        int lat;
        wait_ready(1);
        a = av; b = bv; ib = ibv; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); ib = 1'($urandom);
        lat = 0;
        while (out_valid[1] !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 4);
        chk({tag, "_y"},   32'(y[1]), 32'(ey));
        chk({tag, "_ob"},  32'(ob[1]), 32'(eob));
        chk({tag, "_ovf"}, 32'(ovf[1]), 32'(eovf));
        step();
        chk({tag, "_ov_drop"}, 32'(out_valid[1]), 0);
        chk({tag, "_rdy_back"}, 32'(in_ready[1]), 1);
        chk({tag, "_y_keep"}, 32'(y[1]), 32'(ey));
    endtask

    // Same operands into all three instances, each checked against the model.
    task automatic sweep_op(input logic [15:0] av, input logic [15:0] bv, input logic ibv);
        logic [16:0] d;
        logic [15:0] ey;
        logic        eob, eovf;
        logic        seen [3];
        d    = {1'b0, av} - {1'b0, bv} - 17'(ibv);
        ey   = d[15:0];
        eob  = d[16];
        eovf = (av[15] != bv[15]) && (ey[15] != av[15]);
        for (int i = 0; i < 3; i++) begin
            wait_ready(i);
            seen[i] = 1'b0;
        end
        a = av; b = bv; ib = ibv; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); ib = 1'($urandom);
        for (int lat = 1; lat <= 20; lat++) begin
            step();
            for (int i = 0; i < 3; i++) begin
                if (!seen[i] && out_valid[i] === 1'b1) begin
                    seen[i] = 1'b1;
                    chk($sformatf("sweep_s%0d_lat", i), 32'(lat), 32'(nslices(i)));
                    chk($sformatf("sweep_s%0d_y", i), 32'(y[i]), 32'(ey));
                    chk($sformatf("sweep_s%0d_ob", i), 32'(ob[i]), 32'(eob));
                    chk($sformatf("sweep_s%0d_ovf", i), 32'(ovf[i]), 32'(eovf));
                end
            end
        end
        for (int i = 0; i < 3; i++)
            chk($sformatf("sweep_s%0d_seen", i), 32'(seen[i]), 1);
    endtask

    initial begin
        int lat;

        // Reset state
        rst = 1'b1;
        step();
        step();
        chk("rst_in_ready",  32'(in_ready[1]), 1);
        chk("rst_out_valid", 32'(out_valid[1]), 0);
        chk("rst_y",         32'(y[1]), 0);
        chk("rst_ob",        32'(ob[1]), 0);
        chk("rst_ovf",       32'(ovf[1]), 0);
        rst = 1'b0;
        step();

        // Directed
        do_op("basic",  16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
        do_op("under",  16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        do_op("ib_eq",  16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        do_op("ovf_n",  16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        do_op("ovf_p",  16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);

        // Backpressure: 0x1234 - 0x0034 = 0x1200
        wait_ready(1);
        a = 16'h1234; b = 16'h0034; ib = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (out_valid[1] !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        chk("bp_lat", 32'(lat), 4);
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            a = 16'($urandom); b = 16'($urandom); ib = 1'($urandom);
            step();
            chk("bp_y",        32'(y[1]), 32'h1200);
            chk("bp_ob",       32'(ob[1]), 0);
            chk("bp_ovf",      32'(ovf[1]), 0);
            chk("bp_in_ready", 32'(in_ready[1]), 0);
            chk("bp_out_valid",32'(out_valid[1]), 1);
        end
        a = 16'h0100; b = 16'h0001; ib = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        step();
        chk("bp_xfer_ov",  32'(out_valid[1]), 0);
        chk("bp_xfer_rdy", 32'(in_ready[1]), 1);
        chk("bp_xfer_y",   32'(y[1]), 32'h1200);
        step();
        chk("bp_accept", 32'(in_ready[1]), 0);
        in_valid = 1'b0;
        lat = 0;
        while (out_valid[1] !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        chk("bp_next_lat", 32'(lat), 4);
        chk("bp_next_y",   32'(y[1]), 32'h00FF);
        step();

        // Leaves OB=OVF=1 so the reset below has something to clear
        do_op("pre_rst", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);

        // Reset in the middle of RUN
        wait_ready(1);
        a = 16'hFFFF; b = 16'h0001; ib = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        #3 rst = 1'b1;
        #1;
        chk("mrst_y",        32'(y[1]), 0);
        chk("mrst_ob",       32'(ob[1]), 0);
        chk("mrst_ovf",      32'(ovf[1]), 0);
        chk("mrst_out_valid",32'(out_valid[1]), 0);
        chk("mrst_in_ready", 32'(in_ready[1]), 1);
        #2 rst = 1'b0;
        step();
        do_op("post_rst", 16'h00FF, 16'h0F0F, 1'b0, 16'hF1F0, 1'b1, 1'b0);

        // Sweep over all three slice widths
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (20) step();
        sweep_op(16'h0000, 16'h0000, 1'b1);
        sweep_op(16'hFFFF, 16'h0000, 1'b0);
        sweep_op(16'h8000, 16'h7FFF, 1'b1);
        sweep_op(16'h1234, 16'h0234, 1'b0);
        for (int k = 0; k < 10; k++)
            sweep_op(16'($urandom), 16'($urandom), 1'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sub_serial.md
Name: sub_serial

Overview:
- Multi-cycle, slice-serial subtractor: Y = A - B - IB, computed SLICE bits per cycle, LSB slice first.
- Borrow is carried between slices in a register.
- Counterpart to the combinational adders; used where a wide subtract must be area-cheap.
- Valid/ready handshake on both the operand side and the result side.

Parameters:
- LEN, 16, operand/result width in bits.
- SLICE, 4, bits processed per cycle. LEN must be an integer multiple of SLICE; N = LEN/SLICE.

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- RST  input  1  reset, asynchronous, active-high.
- A  input  LEN  minuend, sampled on start handshake.
- B  input  LEN  subtrahend, sampled on start handshake.
- IB  input  1  borrow-in, sampled on start handshake.
- IN_VALID  input  1  operands present.
- IN_READY  output  1  block can accept operands.
- Y  output  LEN  difference; meaningful only while OUT_VALID=1.
- OB  output  1  borrow-out: 1 iff unsigned A < B + IB.
- OVF  output  1  signed two's-complement overflow of A - B - IB.
- OUT_VALID  output  1  result present.
- OUT_READY  input  1  consumer takes result.

Behaviour:
- Three states: IDLE, RUN, DONE.
- Reset (asynchronous, any state): state=IDLE; Y, OB, OVF, OUT_VALID, slice counter, borrow register and operand registers all cleared to 0.
- IN_READY=1 exactly in IDLE. It is a combinational decode of state and does not depend on IN_VALID.
- IDLE -> RUN on the edge where IN_VALID & IN_READY:
  - latch A, B, IB;
  - load borrow register = IB;
  - clear counter and Y.
- RUN, per edge:
  - Compute {b, d} = A[k] - B[k] - borrow, where k is the counter-indexed slice.
  - Write d into Y slice k.
  - borrow <= b.
  - Counter increments.
  - Occupies exactly N edges.
- On the Nth RUN edge (final slice):
  - OB <= final borrow;
  - OVF <= (A[LEN-1] != B[LEN-1]) & (Y[LEN-1] != A[LEN-1]), evaluated using the MSB slice just computed;
  - state -> DONE; OUT_VALID becomes 1.
- Latency: start handshake at edge t gives OUT_VALID=1 after edge t+N.
- Throughput: one operation per N+2 cycles minimum.
- DONE:
  - Y, OB and OVF are held stable while OUT_VALID=1 and OUT_READY=0 (unbounded backpressure).
  - On the edge with OUT_VALID & OUT_READY: state -> IDLE, OUT_VALID <= 0. Y, OB and OVF keep their last values.
- IN_VALID in RUN or DONE is ignored. Inputs A, B and IB may change freely after the start handshake without affecting the result.
- OUT_READY outside DONE is ignored.
- IDLE with IN_VALID=0: no state change.
- N=1 (SLICE=LEN) is legal: RUN lasts one edge.
- Y during RUN is partially written and must not be interpreted.

Test Plan:
- LEN=16, SLICE=4: A=0x1234, B=0x0234, IB=0, OUT_READY=1 -> OUT_VALID exactly 4 edges after accept; Y=0x1000, OB=0, OVF=0; IN_READY=1 again one edge after the result handshake.
- A=0x0000, B=0x0001, IB=0 -> Y=0xFFFF, OB=1, OVF=0. Then A=0x0005, B=0x0005, IB=1 -> Y=0xFFFF, OB=1, OVF=0.
- Signed overflow:
  - A=0x8000, B=0x0001 -> Y=0x7FFF, OB=0, OVF=1.
  - A=0x7FFF, B=0xFFFF -> Y=0x8000, OB=1, OVF=1.
- Backpressure: hold OUT_READY=0 for 10 cycles after OUT_VALID; keep IN_VALID=1 with new operands and change A/B every cycle -> Y/OB/OVF stay constant, IN_READY=0 throughout. Raise OUT_READY -> one transfer, then the new operands are accepted.
- Reset mid-RUN: assert RST asynchronously after 2 slice edges (between clock edges) -> outputs are 0 and IN_READY=1 immediately. The next operation A=0x00FF, B=0x0F0F gives Y=0xF1F0, OB=1, OVF=0 with no residue from the aborted operation.
- Sweep: random A/B/IB for SLICE in {1, 4, 16}, checked against the reference model Y={A-B-IB}[LEN-1:0], OB=(A<B+IB), OVF as defined; latency always N.
